// File: rtl/uart_pkg.sv
// Shared UART frame definitions. The transmit side uses the same constants and byte type.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line. Both flops reset to 1, the idle level of the line,
// so leaving reset never looks like a start bit.
module uart_sync2 (
    input  logic ser_clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a running byte checksum.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of the FSM (adds 2 cycles of latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 3
) (
    input  logic        ser_clk,
    input  logic        rst_n,
    input  logic        ser_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic [31:0] rx_sum
);

    localparam int CW   = $clog2(CYCLES_PER_BIT);
    localparam int HALF = CYCLES_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);

    if (CYCLES_PER_BIT < 2 || UART_STOP_BITS != 1) begin : g_bad_cfg
        $error("uart_rx: CYCLES_PER_BIT must be >= 2 and the frame must have one stop bit");
    end

    logic rx_line;

`ifdef UART_RX_SYNC_EN
    uart_sync2 u_sync (
        .ser_clk (ser_clk),
        .rst_n   (rst_n),
        .d_i     (ser_rx),
        .q_o     (rx_line)
    );
`else
    assign rx_line = ser_rx;
`endif

    rx_state_e   state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    uart_byte_t  shift_q, shift_d;
    uart_byte_t  data_q, data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [31:0] sum_q, sum_d;

    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            bit_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        sum_d   = sum_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_line) state_d = RX_START;
            end
            RX_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_line, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                // Leave mid stop bit so a start bit right behind it is not missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_line) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        sum_d   = sum_q + {24'b0, shift_q};
                        state_d = RX_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_line) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_error = error_q;
    assign rx_sum   = sum_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table on a CYCLES_PER_BIT=3 receiver, start glitch on a
// CYCLES_PER_BIT=4 receiver, reset mid-frame sequence. Strobe times are in edges from t0.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        ser_clk, rst_n, rx_a, rx_b;
    logic [7:0]  rx_data_a, rx_data_b;
    logic        rx_valid_a, rx_valid_b, rx_error_a, rx_error_b;
    logic [31:0] rx_sum_a, rx_sum_b;

    uart_rx #(.CYCLES_PER_BIT(3)) u_dut_a (
        .ser_clk(ser_clk), .rst_n(rst_n), .ser_rx(rx_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_error(rx_error_a), .rx_sum(rx_sum_a)
    );

    uart_rx #(.CYCLES_PER_BIT(4)) u_dut_b (
        .ser_clk(ser_clk), .rst_n(rst_n), .ser_rx(rx_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_error(rx_error_b), .rx_sum(rx_sum_b)
    );

    initial begin
        ser_clk = 1'b0;
        forever #5 ser_clk = ~ser_clk;
    end

    typedef struct {
        int          at;     // edge that first samples the strobe high
        logic [1:0]  kind;   // {error, valid}
        logic [7:0]  data;
        logic [31:0] sum;
    } ev_t;

    typedef struct {
        logic        rst;
        logic [7:0]  data;
        logic        stop;
        int          low_after;
        int          gap;
        logic [1:0]  kind;
        logic [7:0]  exp_data;
        logic [31:0] exp_sum;
    } vec_t;

    ev_t  exp_a[$], obs_a[$], exp_b[$], obs_b[$];
    vec_t tbl [11];
    int   edge_n = 0;
    int   n_chk = 0, n_fail = 0;

    always @(posedge ser_clk) edge_n <= edge_n + 1;

    // Strobes set by edge k are seen here after edge k, i.e. by edge k+1.
    always @(negedge ser_clk) begin
        if (rst_n && (rx_valid_a || rx_error_a))
            obs_a.push_back('{edge_n + 1, {rx_error_a, rx_valid_a}, rx_data_a, rx_sum_a});
        if (rst_n && (rx_valid_b || rx_error_b))
            obs_b.push_back('{edge_n + 1, {rx_error_b, rx_valid_b}, rx_data_b, rx_sum_b});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic idle(input bit sel, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ser_clk);
            drive(sel, 1'b1);
        end
    endtask

    task automatic low(input bit sel, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ser_clk);
            drive(sel, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data_a", {24'b0, rx_data_a}, 32'h0);
        check("rst_valid_a", {31'b0, rx_valid_a}, 32'h0);
        check("rst_error_a", {31'b0, rx_error_a}, 32'h0);
        check("rst_sum_a", rx_sum_a, 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge ser_clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge ser_clk);
        rst_n = 1'b1;
    endtask

    // Drives start, 8 data bits LSB first, stop; rst_j >= 0 pulses reset during that cycle index.
    task automatic send_frame(input bit sel, input int cpb, input logic [7:0] d, input logic stop,
                              input int rst_j, output int t0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0 = 0;
        for (int j = 0; j < 10 * cpb; j++) begin
            @(negedge ser_clk);
            if (j == 0) t0 = edge_n + 1;
            if (j == rst_j) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
            end
            if (rst_j >= 0 && j == rst_j + 1) rst_n = 1'b1;
            drive(sel, bits[j / cpb]);
        end
    endtask

    task automatic compare(input bit sel);
        int ne, no;
        ev_t e, o;
        ne = sel ? exp_b.size() : exp_a.size();
        no = sel ? obs_b.size() : obs_a.size();
        check(sel ? "strobe_count_b" : "strobe_count_a", no, ne);
        for (int i = 0; i < ne && i < no; i++) begin
            e = sel ? exp_b[i] : exp_a[i];
            o = sel ? obs_b[i] : obs_a[i];
            check($sformatf("ev%0d_%s_time", i, sel ? "b" : "a"), o.at, e.at);
            check($sformatf("ev%0d_%s_kind", i, sel ? "b" : "a"), {30'b0, o.kind}, {30'b0, e.kind});
            check($sformatf("ev%0d_%s_data", i, sel ? "b" : "a"), {24'b0, o.data}, {24'b0, e.data});
            check($sformatf("ev%0d_%s_sum", i, sel ? "b" : "a"), o.sum, e.sum);
        end
    endtask

    initial begin
        int t0;
        //          rst   data   stop low gap kind    data   sum
        tbl[0]  = '{1'b1, 8'h48, 1'b1, 0, 4, 2'b01, 8'h48, 32'h048};
        tbl[1]  = '{1'b1, 8'h48, 1'b1, 0, 0, 2'b01, 8'h48, 32'h048};
        tbl[2]  = '{1'b0, 8'h65, 1'b1, 0, 0, 2'b01, 8'h65, 32'h0AD};
        tbl[3]  = '{1'b0, 8'h6C, 1'b1, 0, 0, 2'b01, 8'h6C, 32'h119};
        tbl[4]  = '{1'b0, 8'h6C, 1'b1, 0, 0, 2'b01, 8'h6C, 32'h185};
        tbl[5]  = '{1'b0, 8'h6F, 1'b1, 0, 3, 2'b01, 8'h6F, 32'h1F4};
        tbl[6]  = '{1'b0, 8'h55, 1'b0, 40, 3, 2'b10, 8'h6F, 32'h1F4};
        tbl[7]  = '{1'b0, 8'h0F, 1'b1, 0, 0, 2'b01, 8'h0F, 32'h203};
        tbl[8]  = '{1'b0, 8'hFF, 1'b1, 0, 0, 2'b01, 8'hFF, 32'h302};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 0, 0, 2'b01, 8'h00, 32'h302};
        tbl[10] = '{1'b0, 8'h80, 1'b1, 0, 6, 2'b01, 8'h80, 32'h382};

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (2) @(negedge ser_clk);
        check_reset_outputs();
        check("rst_sum_b", rx_sum_b, 32'h0);
        rst_n = 1'b1;
        idle(0, 3);

        // One-cycle low on the 4-cycle receiver must be rejected at the mid-bit re-sample.
        low(1, 1);
        idle(1, 12);
        check("glitch_no_strobe_b", obs_b.size(), 0);
        send_frame(1, 4, 8'hA5, 1'b1, -1, t0);
        exp_b.push_back('{t0 + 39 + LAT, 2'b01, 8'hA5, 32'h0A5});
        idle(1, 4 + LAT);

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset();
            send_frame(0, 3, tbl[i].data, tbl[i].stop, -1, t0);
            exp_a.push_back('{t0 + 29 + LAT, tbl[i].kind, tbl[i].exp_data, tbl[i].exp_sum});
            low(0, tbl[i].low_after);
            idle(0, tbl[i].gap);
        end

        // Reset during data bit 4 of 0xFF: aborted frame leaves no strobe and the sum restarts.
        pulse_reset();
        send_frame(0, 3, 8'h12, 1'b1, -1, t0);
        exp_a.push_back('{t0 + 29 + LAT, 2'b01, 8'h12, 32'h012});
        idle(0, 6);
        send_frame(0, 3, 8'hFF, 1'b1, 16, t0);
        idle(0, 5);
        send_frame(0, 3, 8'h33, 1'b1, -1, t0);
        exp_a.push_back('{t0 + 29 + LAT, 2'b01, 8'h33, 32'h033});
        idle(0, 8);

        compare(0);
        compare(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
